// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i
   );
   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i
   );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage issuing loads/stores over a req/ack bus and feeding the MEM/WB register.
// Define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES unacknowledged BUSY cycles.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_i,
   input  logic               RegWrite_i,
   input  logic               MemtoReg_i,
   input  logic               MemRead_i,
   input  logic               MemWrite_i,
   input  logic [31:0]        ALUResult_i,
   input  logic [31:0]        MemWrData_i,
   input  logic [4:0]         RegDest_i,
   output logic               stall_o,
   mem_access_stage_if.master mem,
   output logic               RegWrite_o,
   output logic               MemtoReg_o,
   output logic [31:0]        ALUResult_o,
   output logic [31:0]        MemData_o,
   output logic [4:0]         RegDest_o,
   output logic               err_o
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t      state_q, state_d;
   logic        acc, ack, tmo, fin;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        hrw_q, hrw_d, hmtr_q, hmtr_d;
   logic [4:0]  hdest_q, hdest_d;
   logic        rw_q, rw_d, mtr_q, mtr_d, err_q, err_d;
   logic [31:0] alu_q, alu_d, mdata_q, mdata_d;
   logic [4:0]  dest_q, dest_d;
   assign acc = MemRead_i | MemWrite_i;
   assign ack = (state_q == BUSY) & mem.mem_ack_i;
   assign fin = ack | tmo;
`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // Counter is zero whenever IDLE, so it is already clear on entry to BUSY.
   assign cnt_d = (state_q == BUSY && !mem.mem_ack_i) ? cnt_q + 1'b1 : '0;
   assign tmo   = (state_q == BUSY) && !mem.mem_ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
`else
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_CYCLES;
   assign tmo = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hrw_d   = hrw_q;
      hmtr_d  = hmtr_q;
      hdest_d = hdest_q;
      rw_d    = rw_q;
      mtr_d   = mtr_q;
      alu_d   = alu_q;
      mdata_d = mdata_q;
      dest_d  = dest_q;
      err_d   = 1'b0;
      stall_o = 1'b0;
      if (state_q == IDLE) begin
         stall_o = acc;
         if (acc) begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = MemWrite_i;
            addr_d  = ALUResult_i;
            wdata_d = MemWrData_i;
            hrw_d   = RegWrite_i;
            hmtr_d  = MemtoReg_i;
            hdest_d = RegDest_i;
            rw_d    = 1'b0;
         end else begin
            rw_d   = RegWrite_i;
            mtr_d  = MemtoReg_i;
            alu_d  = ALUResult_i;
            dest_d = RegDest_i;
         end
      end else begin
         // Releasing stall on the completing cycle lets EX/MEM advance on the same edge.
         stall_o = !fin;
         rw_d    = 1'b0;
         if (fin) begin
            state_d = IDLE;
            req_d   = 1'b0;
            rw_d    = hrw_q & ack;
            mtr_d   = hmtr_q;
            alu_d   = addr_q;
            dest_d  = hdest_q;
            mdata_d = (ack && !we_q) ? mem.mem_rdata_i : mdata_q;
            err_d   = tmo;
         end
      end
   end
   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hrw_q   <= 1'b0;
         hmtr_q  <= 1'b0;
         hdest_q <= '0;
         rw_q    <= 1'b0;
         mtr_q   <= 1'b0;
         alu_q   <= '0;
         mdata_q <= '0;
         dest_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hrw_q   <= hrw_d;
         hmtr_q  <= hmtr_d;
         hdest_q <= hdest_d;
         rw_q    <= rw_d;
         mtr_q   <= mtr_d;
         alu_q   <= alu_d;
         mdata_q <= mdata_d;
         dest_q  <= dest_d;
         err_q   <= err_d;
      end
   assign mem.mem_req_o   = req_q;
   assign mem.mem_we_o    = we_q;
   assign mem.mem_addr_o  = addr_q;
   assign mem.mem_wdata_o = wdata_q;
   assign RegWrite_o      = rw_q;
   assign MemtoReg_o      = mtr_q;
   assign ALUResult_o     = alu_q;
   assign MemData_o       = mdata_q;
   assign RegDest_o       = dest_q;
   assign err_o           = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
   logic [31:0] ALUResult_i, MemWrData_i;
   logic [4:0]  RegDest_i;
   logic        stall_o, RegWrite_o, MemtoReg_o, err_o;
   logic [31:0] ALUResult_o, MemData_o;
   logic [4:0]  RegDest_o;
   int          tests = 0;
   int          fails = 0;
   mem_access_stage_if bus ();
   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_i(rst_i),
      .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .ALUResult_i(ALUResult_i), .MemWrData_i(MemWrData_i), .RegDest_i(RegDest_i),
      .stall_o(stall_o), .mem(bus),
      .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ALUResult_o(ALUResult_o),
      .MemData_o(MemData_o), .RegDest_o(RegDest_o), .err_o(err_o)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic rw, mtr, mr, mw, input logic [31:0] alu, wd, input logic [4:0] rd);
      RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
      ALUResult_i = alu; MemWrData_i = wd; RegDest_i = rd;
   endtask
   task automatic nop();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
   endtask
   task automatic test_reset();
      nop();
      bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'h0;
      step(); step();
      tests++; if (bus.mem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.mem_req_o); end
      tests++; if ({RegWrite_o, MemtoReg_o, err_o, stall_o} !== 4'b0) begin fails++; $display("FAIL reset_ctl: got %b want 0000", {RegWrite_o, MemtoReg_o, err_o, stall_o}); end
      tests++; if ({ALUResult_o, MemData_o, RegDest_o, bus.mem_addr_o} !== 101'b0) begin fails++; $display("FAIL reset_data: got %h want 0", {ALUResult_o, MemData_o, RegDest_o, bus.mem_addr_o}); end
      rst_i = 1'b0;
   endtask
   task automatic test_alu();
      int st = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
      #1 if (stall_o) st++;
      step();
      nop();
      #1 if (stall_o) st++;
      tests++; if (st !== 0) begin fails++; $display("FAIL alu_stall: got %0d high cycles want 0", st); end
      tests++; if (RegWrite_o !== 1'b1 || MemtoReg_o !== 1'b0) begin fails++; $display("FAIL alu_ctl: got rw=%b mtr=%b want rw=1 mtr=0", RegWrite_o, MemtoReg_o); end
      tests++; if (ALUResult_o !== 32'h1234 || RegDest_o !== 5'd5) begin fails++; $display("FAIL alu_data: got %h/%0d want 1234/5", ALUResult_o, RegDest_o); end
      step();
   endtask
   task automatic test_load();
      int st = 0;
      int rwh = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF; nop(); end
         #1 if (stall_o) st++;
         if (i == 1) begin
            tests++; if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 32'h100) begin fails++; $display("FAIL load_req: got req=%b we=%b addr=%h want 1/0/100", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o); end
         end
         if (i > 0 && RegWrite_o) rwh++;
         step();
      end
      bus.mem_ack_i = 1'b0;
      tests++; if (st !== 4) begin fails++; $display("FAIL load_stall: got %0d cycles want 4", st); end
      tests++; if (rwh !== 0) begin fails++; $display("FAIL load_bubble: got %0d RegWrite cycles want 0", rwh); end
      tests++; if (MemData_o !== 32'hDEADBEEF || MemtoReg_o !== 1'b1 || RegWrite_o !== 1'b1) begin fails++; $display("FAIL load_wb: got %h mtr=%b rw=%b want deadbeef/1/1", MemData_o, MemtoReg_o, RegWrite_o); end
      tests++; if (RegDest_o !== 5'd7 || ALUResult_o !== 32'h100 || bus.mem_req_o !== 1'b0) begin fails++; $display("FAIL load_dest: got %0d/%h req=%b want 7/100/0", RegDest_o, ALUResult_o, bus.mem_req_o); end
   endtask
   task automatic test_store_then_load();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 5'd0);
      #1;
      tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL store_stall: got %b want 1", stall_o); end
      step();
      tests++; if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h200 || bus.mem_wdata_o !== 32'hCAFEF00D) begin fails++; $display("FAIL store_bus: got req=%b we=%b %h %h want 1/1/200/cafef00d", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o); end
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h77777777;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9);
      #1;
      tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL store_ack_stall: got %b want 0", stall_o); end
      step();
      bus.mem_ack_i = 1'b0;
      tests++; if (MemData_o !== 32'hDEADBEEF || ALUResult_o !== 32'h200 || bus.mem_req_o !== 1'b0) begin fails++; $display("FAIL store_wb: got %h/%h req=%b want deadbeef/200/0", MemData_o, ALUResult_o, bus.mem_req_o); end
      step();
      tests++; if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 32'h300) begin fails++; $display("FAIL b2b_issue: got req=%b we=%b %h want 1/0/300", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o); end
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h11112222;
      nop();
      step();
      bus.mem_ack_i = 1'b0;
      tests++; if (MemData_o !== 32'h11112222 || RegDest_o !== 5'd9 || RegWrite_o !== 1'b1) begin fails++; $display("FAIL b2b_wb: got %h/%0d rw=%b want 11112222/9/1", MemData_o, RegDest_o, RegWrite_o); end
   endtask
   task automatic test_read_write();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h55AA55AA, 5'd3);
      step();
      tests++; if (bus.mem_we_o !== 1'b1 || bus.mem_wdata_o !== 32'h55AA55AA) begin fails++; $display("FAIL rw_we: got we=%b %h want 1/55aa55aa", bus.mem_we_o, bus.mem_wdata_o); end
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h99999999;
      nop();
      step();
      bus.mem_ack_i = 1'b0;
      tests++; if (MemData_o !== 32'h11112222 || RegDest_o !== 5'd3) begin fails++; $display("FAIL rw_hold: got %h/%0d want 11112222/3", MemData_o, RegDest_o); end
   endtask
   task automatic test_ack_idle();
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hBAD0BAD0;
      #1;
      tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL idle_ack_stall: got %b want 0", stall_o); end
      step();
      bus.mem_ack_i = 1'b0;
      tests++; if (bus.mem_req_o !== 1'b0 || MemData_o !== 32'h11112222) begin fails++; $display("FAIL idle_ack: got req=%b %h want 0/11112222", bus.mem_req_o, MemData_o); end
   endtask
`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      int st = 0;
      int er = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd4);
      step();
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) nop();
         #1 if (stall_o) st++;
         if (err_o) er++;
         step();
      end
      tests++; if (st !== 3) begin fails++; $display("FAIL tmo_stall: got %0d BUSY stall cycles want 3", st); end
      tests++; if (err_o !== 1'b1 || er !== 0) begin fails++; $display("FAIL tmo_err: got %b (early %0d) want 1 (0)", err_o, er); end
      tests++; if (RegWrite_o !== 1'b0 || bus.mem_req_o !== 1'b0 || ALUResult_o !== 32'h500 || RegDest_o !== 5'd4) begin fails++; $display("FAIL tmo_wb: got rw=%b req=%b %h/%0d want 0/0/500/4", RegWrite_o, bus.mem_req_o, ALUResult_o, RegDest_o); end
      step();
      tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL tmo_pulse: got %b want 0", err_o); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 5'd6);
      step();
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) begin bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hA5A5A5A5; nop(); end
         step();
      end
      bus.mem_ack_i = 1'b0;
      tests++; if (err_o !== 1'b0 || RegWrite_o !== 1'b1 || MemData_o !== 32'hA5A5A5A5) begin fails++; $display("FAIL tmo_ack_wins: got err=%b rw=%b %h want 0/1/a5a5a5a5", err_o, RegWrite_o, MemData_o); end
   endtask
`else
   task automatic test_no_timeout();
      int st = 0;
      int er = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd4);
      step();
      for (int i = 0; i < 20; i++) begin
         #1 if (stall_o) st++;
         if (err_o) er++;
         step();
      end
      tests++; if (st !== 20 || er !== 0) begin fails++; $display("FAIL no_tmo: got stall %0d err %0d want 20/0", st, er); end
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hA5A5A5A5;
      nop();
      step();
      bus.mem_ack_i = 1'b0;
      tests++; if (RegWrite_o !== 1'b1 || MemData_o !== 32'hA5A5A5A5 || err_o !== 1'b0) begin fails++; $display("FAIL no_tmo_done: got rw=%b %h err=%b want 1/a5a5a5a5/0", RegWrite_o, MemData_o, err_o); end
   endtask
`endif
   task automatic test_reset_mid_busy();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd8);
      step();
      tests++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h40) begin fails++; $display("FAIL rstb_pre: got req=%b %h want 1/40", bus.mem_req_o, bus.mem_addr_o); end
      nop();
      #2 rst_i = 1'b1;
      #1;
      tests++; if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h0 || MemData_o !== 32'h0 || ALUResult_o !== 32'h0 || RegDest_o !== 5'd0 || MemtoReg_o !== 1'b0) begin fails++; $display("FAIL rstb_async: got req=%b %h %h %h %0d want all 0", bus.mem_req_o, bus.mem_addr_o, MemData_o, ALUResult_o, RegDest_o); end
      #1 rst_i = 1'b0;
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hABC, 32'h0, 5'd2);
      step();
      nop();
      tests++; if (RegWrite_o !== 1'b1 || ALUResult_o !== 32'hABC || bus.mem_req_o !== 1'b0) begin fails++; $display("FAIL rstb_idle: got rw=%b %h req=%b want 1/abc/0", RegWrite_o, ALUResult_o, bus.mem_req_o); end
   endtask
   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store_then_load();
      test_read_write();
      test_ack_idle();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
